// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, one operation in flight.
// ROTATE mode produces cos/sin of an angle in [-pi,+pi]; VECTOR mode produces
// magnitude and atan2 of (x,y). A quadrant pre-rotation brings every operand
// into the convergence range of the micro-rotations, and a final SCALE cycle
// removes the CORDIC gain.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. Input side: o_ready is high only in IDLE, and
// i_valid outside IDLE is ignored. Output side: o_valid is held together with
// o_a/o_b/o_z, unchanged, until a rising edge where i_ready is high.
module cordic_iter #(
  parameter int FRAC  = 16,
  parameter int W     = 24,
  parameter int ITER  = 16,
  parameter int GUARD = 2,
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_mode,
  input  logic [W-1:0]  i_x,
  input  logic [W-1:0]  i_y,
  input  logic [W-1:0]  i_theta,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [W-1:0]  o_a,
  output logic [W-1:0]  o_b,
  output logic [W-1:0]  o_z,
  output logic [1:0]    o_dbg_state,
  output logic [CW-1:0] o_dbg_count
);

  localparam int XW = W + GUARD;  // x/y width with headroom for the gain
  localparam int PW = XW + W;     // scale product width
  localparam int FX = 60;         // fraction bits of the elaboration-time math

  // atan(1/n) in Q.FX, by its alternating power series (|1/n| <= 1/2 here).
  function automatic longint atan_inv(input longint n);
    longint term;
    longint acc;
    term = (64'sd1 <<< FX) / n;
    acc  = term;
    for (int k = 1; k < 40; k++) begin
      term = term / (n * n);
      if ((k % 2) == 1) acc = acc - term / longint'(2 * k + 1);
      else              acc = acc + term / longint'(2 * k + 1);
    end
    return acc;
  endfunction

  // Round a Q.FX value to Q.FRAC.
  function automatic longint fx_round(input longint v);
    return (v + (64'sd1 <<< (FX - FRAC - 1))) >>> (FX - FRAC);
  endfunction

  // pi/4 by Machin's formula, so no table entry relies on a slow series.
  localparam longint PI4_FX = 64'sd4 * atan_inv(64'sd5) - atan_inv(64'sd239);

  function automatic logic [ITER*W-1:0] build_atan();
    logic [ITER*W-1:0] tab;
    longint            a;
    tab = '0;
    for (int i = 0; i < ITER; i++) begin
      if (i == 0) a = PI4_FX;
      else        a = atan_inv(64'sd1 <<< i);
      tab[i*W +: W] = W'(fx_round(a));
    end
    return tab;
  endfunction

  localparam logic [ITER*W-1:0] ATAN_TAB = build_atan();
  localparam logic signed [W-1:0]  PI_2  = W'(fx_round(64'sd2 * PI4_FX));
  localparam logic signed [W-1:0]  K_INV =
    W'((64'sd6072529350 * (64'sd1 <<< FRAC) + 64'sd5000000000) / 64'sd10000000000);
  localparam logic signed [XW-1:0] ONE_X = XW'(64'sd1 <<< FRAC);
  localparam logic signed [PW-1:0] SAT_MAX = {{(XW + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(XW + 1){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [W-1:0]   z_q, z_d;
  logic                  mode_q, mode_d;
  logic                  zero_q, zero_d;   // VECTOR operand was (0,0)
  logic [W-1:0]          a_q, a_d, b_q, b_d, zo_q, zo_d;

  // Operand views used by the pre-rotation.
  logic signed [XW-1:0]  in_x, in_y;
  logic signed [W-1:0]   in_th;
  // Per-iteration terms.
  logic signed [XW-1:0]  x_sh, y_sh;
  logic signed [W-1:0]   atan_i;
  logic                  d_neg;
  logic signed [PW-1:0]  prod_x, prod_y;

  // Product >>> FRAC, clamped to the signed W-bit output range.
  function automatic logic [W-1:0] sat_scale(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> FRAC;
    if (s > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (s < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return s[W-1:0];
  endfunction

  // Next-state logic: pre-rotation on accept, micro-rotations, gain removal, hold.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mode_d  = mode_q;
    zero_d  = zero_q;
    a_d     = a_q;
    b_d     = b_q;
    zo_d    = zo_q;

    in_x   = XW'($signed(i_x));
    in_y   = XW'($signed(i_y));
    in_th  = $signed(i_theta);
    x_sh   = x_q >>> count_q;
    y_sh   = y_q >>> count_q;
    atan_i = $signed(ATAN_TAB[int'(count_q)*W +: W]);
    // VECTOR drives y toward zero; ROTATE drives z toward zero.
    d_neg  = mode_q ? (y_q >= 0) : (z_q < 0);
    prod_x = PW'(x_q) * PW'(K_INV);
    prod_y = PW'(y_q) * PW'(K_INV);

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          mode_d  = i_mode;
          zero_d  = (i_x == '0) && (i_y == '0);
          count_d = '0;
          state_d = RUN;
          if (!i_mode) begin
            if (in_th > PI_2) begin
              x_d = '0;     y_d = ONE_X;  z_d = in_th - PI_2;
            end else if (in_th < -PI_2) begin
              x_d = '0;     y_d = -ONE_X; z_d = in_th + PI_2;
            end else begin
              x_d = ONE_X;  y_d = '0;     z_d = in_th;
            end
          end else begin
            if (in_x < 0 && in_y >= 0) begin
              x_d = in_y;   y_d = -in_x;  z_d = PI_2;
            end else if (in_x < 0) begin
              x_d = -in_y;  y_d = in_x;   z_d = -PI_2;
            end else begin
              x_d = in_x;   y_d = in_y;   z_d = '0;
            end
          end
        end
      end
      RUN: begin
        if (d_neg) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        if (count_q == CW'(ITER - 1)) begin
          count_d = '0;
          state_d = SCALE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      SCALE: begin
        a_d     = (mode_q && zero_q) ? '0 : sat_scale(prod_x);
        b_d     = mode_q ? '0 : sat_scale(prod_y);
        zo_d    = (mode_q && zero_q) ? '0 : z_q;
        state_d = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
      a_q     <= a_d;
      b_q     <= b_d;
      zo_q    <= zo_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_a         = a_q;
  assign o_b         = b_q;
  assign o_z         = zo_q;
  assign o_dbg_state = state_q;
  assign o_dbg_count = count_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Bench for cordic_iter: a real-arithmetic model fills the expected queues when
// an operation is driven; results are popped and compared when o_valid rises.
module tb_cordic_iter;

  localparam int FRAC  = 16;
  localparam int W     = 24;
  localparam int ITER  = 16;
  localparam int GUARD = 2;
  localparam int CW    = $clog2(ITER);
  localparam int TOL   = ITER / 4 + 2;
  localparam int PI_FX = 205887;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          i_mode = 1'b0;
  logic [W-1:0]  i_x = '0;
  logic [W-1:0]  i_y = '0;
  logic [W-1:0]  i_theta = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [W-1:0]  o_a, o_b, o_z;
  logic [1:0]    o_dbg_state;
  logic [CW-1:0] o_dbg_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] exp_z_q[$];
  logic [2:0]   exp_m_q[$];   // which of a/b/z to compare
  int           tol_q[$];

  cordic_iter #(.FRAC(FRAC), .W(W), .ITER(ITER), .GUARD(GUARD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_x(i_x), .i_y(i_y), .i_theta(i_theta),
    .o_valid(o_valid), .i_ready(i_ready), .o_a(o_a), .o_b(o_b), .o_z(o_z),
    .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Time limit
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int sv(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic real to_real(input logic [W-1:0] v);
    return $itor(sv(v)) / 65536.0;
  endfunction

  function automatic logic [W-1:0] to_fx(input real v);
    int r;
    if (v >= 0.0) r = $rtoi(v * 65536.0 + 0.5);
    else          r = -$rtoi(-v * 65536.0 + 0.5);
    return W'(r);
  endfunction

  // Present one operand at a negedge and hold it through the accepting edge.
  task automatic send(input logic mode, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] th);
    int waitc;
    waitc = 0;
    while (!o_ready && waitc < 50) begin
      @(negedge i_clk);
      waitc++;
    end
    check("accept_ready", int'(o_ready), 1, 0);
    i_mode  = mode;
    i_x     = x;
    i_y     = y;
    i_theta = th;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  // Model the operation, queue the expectation, then drive it.
  task automatic drive_op(input logic mode, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] th, input int tol);
    real rx, ry, rt;
    rx = to_real(x);
    ry = to_real(y);
    rt = to_real(th);
    if (!mode) begin
      exp_a_q.push_back(to_fx($cos(rt)));
      exp_b_q.push_back(to_fx($sin(rt)));
      exp_z_q.push_back('0);
      exp_m_q.push_back(3'b011);
      tol_q.push_back(tol);
    end else if (x == '0 && y == '0) begin
      exp_a_q.push_back('0);
      exp_b_q.push_back('0);
      exp_z_q.push_back('0);
      exp_m_q.push_back(3'b111);
      tol_q.push_back(0);
    end else begin
      exp_a_q.push_back(to_fx($sqrt(rx * rx + ry * ry)));
      exp_b_q.push_back('0);
      exp_z_q.push_back(to_fx($atan2(ry, rx)));
      exp_m_q.push_back(3'b111);
      tol_q.push_back(tol);
    end
    send(mode, x, y, th);
  endtask

  // Wait for the result (called at the negedge just after the accept edge).
  task automatic collect(input string nm);
    int           cyc;
    logic         got;
    logic [W-1:0] ea, eb, ez;
    logic [2:0]   m;
    int           tol;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < ITER + 20) begin
      @(negedge i_clk);
      cyc++;
      if (cyc == 1) check({nm, "_busy_ready"}, int'(o_ready), 0, 0);
      if (o_valid) got = 1'b1;
    end
    check({nm, "_latency"}, cyc, ITER + 1, 0);
    if (exp_a_q.size() > 0) begin
      ea  = exp_a_q.pop_front();
      eb  = exp_b_q.pop_front();
      ez  = exp_z_q.pop_front();
      m   = exp_m_q.pop_front();
      tol = tol_q.pop_front();
      if (m[0]) check({nm, "_a"}, sv(o_a), sv(ea), tol);
      if (m[1]) check({nm, "_b"}, sv(o_b), sv(eb), tol);
      if (m[2]) check({nm, "_z"}, sv(o_z), sv(ez), tol);
    end
    if (i_ready) begin
      @(negedge i_clk);
      check({nm, "_consumed_valid"}, int'(o_valid), 0, 0);
      check({nm, "_consumed_ready"}, int'(o_ready), 1, 0);
    end
  endtask

  initial begin
    logic [W-1:0] ha, hb, hz;
    int           waitc;
    logic         seen;
    int           th, xm, ym;

    // Reset
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_ready", int'(o_ready), 1, 0);
    check("rst_valid", int'(o_valid), 0, 0);
    check("rst_a", sv(o_a), 0, 0);
    check("rst_b", sv(o_b), 0, 0);
    check("rst_z", sv(o_z), 0, 0);
    check("rst_count", int'(o_dbg_count), 0, 0);

    // Directed ROTATE cases
    drive_op(1'b0, '0, '0, 24'h000000, 3);  collect("rot_0");
    drive_op(1'b0, '0, '0, 24'h008610, 3);  collect("rot_pi6");
    drive_op(1'b0, '0, '0, 24'h030000, 3);  collect("rot_3p0");
    drive_op(1'b0, '0, '0, 24'hFD0000, 3);  collect("rot_m3p0");

    // Directed VECTOR cases, including every pre-rotation quadrant and (0,0)
    drive_op(1'b1, 24'h030000, 24'h040000, '0, 3);  collect("vec_3_4");
    drive_op(1'b1, 24'hFD0000, 24'h040000, '0, 3);  collect("vec_m3_4");
    drive_op(1'b1, 24'hFD0000, 24'hFC0000, '0, 3);  collect("vec_m3_m4");
    drive_op(1'b1, 24'h030000, 24'hFC0000, '0, 3);  collect("vec_3_m4");
    drive_op(1'b1, 24'h000000, 24'h000000, '0, 0);  collect("vec_zero");

    // Random ROTATE over [-pi,+pi]
    for (int k = 0; k < 8; k++) begin
      th = int'($urandom_range(0, 2 * PI_FX)) - PI_FX;
      drive_op(1'b0, '0, '0, W'(th), TOL);
      collect("rot_rand");
    end

    // Random VECTOR, |x| in [1,4], y in [-4,4]
    for (int k = 0; k < 8; k++) begin
      xm = int'($urandom_range(65536, 262144));
      if ($urandom_range(0, 1) == 1) xm = -xm;
      ym = int'($urandom_range(0, 524288)) - 262144;
      drive_op(1'b1, W'(xm), W'(ym), '0, TOL);
      collect("vec_rand");
    end

    // Output hold under back-pressure; extra i_valid pulses must be ignored
    i_ready = 1'b0;
    drive_op(1'b0, '0, '0, 24'h008610, 3);
    collect("hold_op");
    ha = o_a;
    hb = o_b;
    hz = o_z;
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      i_mode  = 1'($urandom_range(0, 1));
      i_theta = W'($urandom_range(0, 65535));
      i_x     = W'($urandom_range(0, 65535));
      @(negedge i_clk);
      check("hold_a", sv(o_a), sv(ha), 0);
      check("hold_b", sv(o_b), sv(hb), 0);
      check("hold_z", sv(o_z), sv(hz), 0);
      check("hold_valid", int'(o_valid), 1, 0);
      check("hold_ready", int'(o_ready), 0, 0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    check("release_valid", int'(o_valid), 0, 0);
    check("release_ready", int'(o_ready), 1, 0);
    seen = 1'b0;
    for (int k = 0; k < ITER + 4; k++) begin
      @(negedge i_clk);
      if (o_valid || !o_ready) seen = 1'b1;
    end
    check("hold_no_queued_op", int'(seen), 0, 0);

    // Back-to-back: accept right after consume
    drive_op(1'b0, '0, '0, 24'hFF79F0, 3);  collect("rot_mpi6");

    // Reset mid-RUN aborts the operation
    send(1'b0, '0, '0, 24'h008610);
    waitc = 0;
    while (o_dbg_count != CW'(5) && waitc < ITER + 10) begin
      @(negedge i_clk);
      waitc++;
    end
    check("abort_count5", int'(o_dbg_count), 5, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("abort_valid", int'(o_valid), 0, 0);
    check("abort_ready", int'(o_ready), 1, 0);
    check("abort_count", int'(o_dbg_count), 0, 0);
    seen = 1'b0;
    for (int k = 0; k < ITER + 5; k++) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    check("abort_no_result", int'(seen), 0, 0);
    drive_op(1'b0, '0, '0, 24'h000000, 3);  collect("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
